// File: rtl/serial_bit_feeder.sv
// Serialises a parallel word onto x, one bit per bit_en tick; optional parity via SERIAL_FEEDER_PARITY_EN.
// Latency: first bit on x the cycle after acceptance, done one cycle after the last bit.
// Backpressure: din_ready is low for the whole frame and returns high in the done cycle.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(FRAME - 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr_next;
    logic             bit_next;
`ifdef SERIAL_FEEDER_PARITY_EN
    logic             par;
`endif

    assign din_ready = (state == IDLE);

    // The bit about to be sent always sits at the outgoing end of sr.
    always_comb begin
        sr_next  = '0;
        bit_next = 1'b0;
        if (MSB_FIRST) begin
            sr_next  = sr << 1;
            bit_next = sr[WIDTH-2];
        end else begin
            sr_next  = sr >> 1;
            bit_next = sr[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (din_valid) begin
                        sr      <= din;
                        cnt     <= '0;
                        x       <= MSB_FIRST ? din[WIDTH-1] : din[0];
                        x_valid <= 1'b1;
                        busy    <= 1'b1;
                        state   <= SHIFT;
`ifdef SERIAL_FEEDER_PARITY_EN
                        par     <= ^din;
`endif
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        if (cnt == LAST_CNT) begin
                            state   <= IDLE;
                            x       <= 1'b0;
                            x_valid <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                            sr  <= sr_next;
`ifdef SERIAL_FEEDER_PARITY_EN
                            x   <= (cnt == LAST_DATA) ? par : bit_next;
`else
                            x   <= bit_next;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SERIAL_FEEDER_PARITY_EN
    logic unused_last_data;
    assign unused_last_data = ^LAST_DATA;
`endif

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench: MSB-first and LSB-first instances share stimulus and are checked against hand-written bit patterns.
module tb_serial_bit_feeder;

`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       bit_en;
    logic       rdy_m, x_m, xv_m, busy_m, done_m;
    logic       rdy_l, x_l, xv_l, busy_l, done_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .bit_en(bit_en), .x(x_m), .x_valid(xv_m), .busy(busy_m), .done(done_m)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .bit_en(bit_en), .x(x_l), .x_valid(xv_l), .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Patterns are written first-transmitted bit in position 7.
    function automatic logic expb(input logic [7:0] pat, input int k, input logic p);
        return (k < 8) ? pat[7-k] : p;
    endfunction

    task automatic check_idle_after_frame(input string tag);
        chk({tag, "_done_m"}, done_m, 1);
        chk({tag, "_done_l"}, done_l, 1);
        chk({tag, "_xv_m"}, xv_m, 0);
        chk({tag, "_x_m"}, x_m, 0);
        chk({tag, "_busy_m"}, busy_m, 0);
        chk({tag, "_rdy_m"}, rdy_m, 1);
        chk({tag, "_rdy_l"}, rdy_l, 1);
    endtask

    // Full frame at bit_en=1; din is scribbled after acceptance to show it is not resampled.
    task automatic send_frame(input string tag, input logic [7:0] w, input logic [7:0] em,
                              input logic [7:0] el, input logic p);
        din = w; din_valid = 1'b1; bit_en = 1'b1;
        step();
        din_valid = 1'b0; din = ~w;
        for (int k = 0; k < FRAME; k++) begin
            chk({tag, "_x_m"}, x_m, expb(em, k, p));
            chk({tag, "_x_l"}, x_l, expb(el, k, p));
            chk({tag, "_xv"}, {xv_m, xv_l}, 2'b11);
            chk({tag, "_busy"}, {busy_m, busy_l}, 2'b11);
            chk({tag, "_rdy"}, {rdy_m, rdy_l}, 2'b00);
            chk({tag, "_nodone"}, {done_m, done_l}, 2'b00);
            step();
        end
        check_idle_after_frame(tag);
        step();
        chk({tag, "_done_clr"}, {done_m, done_l}, 2'b00);
        chk({tag, "_gap_xv"}, {xv_m, xv_l}, 2'b00);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; din = 8'h00; din_valid = 1'b0; bit_en = 1'b0;
        step();
        chk("rst_x", {x_m, x_l}, 2'b00);
        chk("rst_xv", {xv_m, xv_l}, 2'b00);
        chk("rst_busy", {busy_m, busy_l}, 2'b00);
        chk("rst_done", {done_m, done_l}, 2'b00);
        chk("rst_rdy", {rdy_m, rdy_l}, 2'b11);
        rst = 1'b0;
        step();

        // MSB/LSB ordering; parity bits: A5->0, 0D->1, 07->1
        send_frame("a5", 8'hA5, 8'b10100101, 8'b10100101, 1'b0);
        send_frame("0d", 8'h0D, 8'b00001101, 8'b10110000, 1'b1);
        send_frame("07", 8'h07, 8'b00000111, 8'b11100000, 1'b1);

        // Half-rate bit_en: every bit held for two cycles, acceptance with bit_en low.
        din = 8'hF0; din_valid = 1'b1; bit_en = 1'b0;
        step();
        din_valid = 1'b0;
        ndone = 0;
        for (int k = 0; k < FRAME; k++) begin
            for (int h = 0; h < 2; h++) begin
                chk("half_x_m", x_m, expb(8'b11110000, k, 1'b0));
                chk("half_x_l", x_l, expb(8'b00001111, k, 1'b0));
                chk("half_xv", xv_m, 1);
                bit_en = (h == 1);
                step();
                ndone += int'(done_m);
            end
        end
        chk("half_done_now", done_m, 1);
        chk("half_xv_end", xv_m, 0);
        for (int c = 0; c < 6; c++) begin
            bit_en = c[0];
            step();
            ndone += int'(done_m);
        end
        chk("half_done_once", ndone, 1);

        // din_valid held with a new word during a frame; accepted in the done cycle.
        bit_en = 1'b1; din = 8'hA5; din_valid = 1'b1;
        step();
        din = 8'h33;
        for (int k = 0; k < FRAME; k++) begin
            chk("hold_x_m", x_m, expb(8'b10100101, k, 1'b0));
            chk("hold_rdy", rdy_m, 0);
            step();
        end
        check_idle_after_frame("hold");
        step();
        chk("hold_next_xv", {xv_m, xv_l}, 2'b11);
        chk("hold_next_x_m", x_m, 0);
        chk("hold_next_x_l", x_l, 1);
        chk("hold_next_done", done_m, 0);
        din_valid = 1'b0;
        for (int k = 1; k < FRAME; k++) begin
            step();
            chk("hold33_x_m", x_m, expb(8'b00110011, k, 1'b0));
        end
        step();
        chk("hold33_done", done_m, 1);
        step();

        // Reset after the third bit of FF: abort without done.
        din = 8'hFF; din_valid = 1'b1; bit_en = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        step();
        chk("abort_third", {x_m, xv_m}, 2'b11);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_x", {x_m, x_l}, 2'b00);
        chk("abort_xv", {xv_m, xv_l}, 2'b00);
        chk("abort_busy", {busy_m, busy_l}, 2'b00);
        chk("abort_done", {done_m, done_l}, 2'b00);
        chk("abort_rdy", {rdy_m, rdy_l}, 2'b11);
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            ndone += int'(done_m) + int'(done_l);
        end
        chk("abort_no_done", ndone, 0);
        send_frame("fresh", 8'h0D, 8'b00001101, 8'b10110000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
